// File: rtl/mem_bus_unit.sv
// mem_bus_unit: bus interface unit between the LEGv8 core and one shared,
// handshaked memory bus. Arbitrates instruction fetch against data access
// (round-robin), builds byte enables / lane-shifted store data, extends load
// data, and reports misalignment, slave errors and timeouts as sticky faults.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_valid)
//   if_inst/if_valid              fetched instruction, one-cycle completion pulse
//   d_read/d_write/d_size/d_signed/d_addr/d_wdata   data request (held until d_valid)
//   d_rdata/d_valid/d_err         extended load data, completion pulse, fault qualifier
//   stall                         core must hold PC and pipeline
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata        bus master outputs
//   bus_rdata/bus_ack/bus_err     bus slave response
//   fault/fault_addr              sticky fault flag and address of the first fault
module mem_bus_unit #(
    parameter int unsigned WORD      = 64,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned INST_SIZE = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic [INST_SIZE-1:0] if_inst,
    output logic                 if_valid,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [1:0]           d_size,
    input  logic                 d_signed,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [WORD-1:0]      d_wdata,
    output logic [WORD-1:0]      d_rdata,
    output logic                 d_valid,
    output logic                 d_err,
    output logic                 stall,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic [WORD/8-1:0]    bus_be,
    output logic [WORD-1:0]      bus_wdata,
    input  logic [WORD-1:0]      bus_rdata,
    input  logic                 bus_ack,
    input  logic                 bus_err,
    output logic                 fault,
    output logic [ADDR_W-1:0]    fault_addr
);
    localparam int unsigned BE_W    = WORD / 8;
    localparam int unsigned OFF_W   = $clog2(BE_W);
    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned LANE_SH = (WORD > INST_SIZE) ? INST_SIZE : 32'd0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 32'd0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DACC = 2'd1;
    localparam logic [1:0] S_FACC = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]           state, state_nx;
    logic                 prefer_data, prefer_data_nx;
    logic [CNT_W-1:0]     tmo_cnt, tmo_cnt_nx;
    logic [OFF_W-1:0]     lat_off, lat_off_nx;
    logic [1:0]           lat_size, lat_size_nx;
    logic                 lat_signed, lat_signed_nx;
    logic                 lat_lane, lat_lane_nx;
    logic [ADDR_W-1:0]    lat_addr, lat_addr_nx;

    logic [INST_SIZE-1:0] if_inst_nx;
    logic                 if_valid_nx, d_valid_nx, d_err_nx;
    logic [WORD-1:0]      d_rdata_nx, bus_wdata_nx;
    logic                 bus_req_nx, bus_we_nx, fault_nx;
    logic [ADDR_W-1:0]    bus_addr_nx, fault_addr_nx;
    logic [BE_W-1:0]      bus_be_nx;

    logic                 d_req, d_bad, f_bad, timed_out, raise_fault;
    logic [OFF_W-1:0]     d_off, d_amask;
    logic [BE_W-1:0]      be_base;
    logic [ADDR_W-1:0]    fault_src;
    logic [WORD-1:0]      rd_shift, ld_keep, ld_data, inst_shift;
    logic                 ld_msb;

    // Request decode: size mask, alignment and base byte-enable pattern
    always_comb begin
        d_amask = '0;
        be_base = '0;
        case (d_size)
            2'b00:   begin d_amask = OFF_W'(3'd0); be_base = BE_W'(8'h01); end
            2'b01:   begin d_amask = OFF_W'(3'd1); be_base = BE_W'(8'h03); end
            2'b10:   begin d_amask = OFF_W'(3'd3); be_base = BE_W'(8'h0F); end
            default: begin d_amask = OFF_W'(3'd7); be_base = BE_W'(8'hFF); end
        endcase
    end

    assign d_req     = d_read | d_write;
    assign d_off     = d_addr[OFF_W-1:0];
    assign d_bad     = (d_read & d_write) | (|(d_off & d_amask)) | ((WORD == 32) && (d_size == 2'b11));
    assign f_bad     = |if_addr[1:0];
    assign timed_out = (TIMEOUT != 0) && (tmo_cnt == CNT_LAST);
    assign stall     = (d_req & ~d_valid) | (if_req & ~if_valid);

    // Load extraction: shift the addressed lane down, mask to size, extend
    always_comb begin
        rd_shift = bus_rdata >> {lat_off, 3'b000};
        ld_keep  = '1;
        ld_msb   = rd_shift[WORD-1];
        case (lat_size)
            2'b00:   begin ld_keep = WORD'(64'hFF);        ld_msb = rd_shift[7];  end
            2'b01:   begin ld_keep = WORD'(64'hFFFF);      ld_msb = rd_shift[15]; end
            2'b10:   begin ld_keep = WORD'(64'hFFFF_FFFF); ld_msb = rd_shift[31]; end
            default: begin ld_keep = '1;                   ld_msb = rd_shift[WORD-1]; end
        endcase
        ld_data    = (rd_shift & ld_keep) | ((lat_signed & ld_msb) ? ~ld_keep : '0);
        inst_shift = bus_rdata >> (lat_lane ? LANE_SH : 32'd0);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx       = state;
        prefer_data_nx = prefer_data;
        tmo_cnt_nx     = tmo_cnt;
        lat_off_nx     = lat_off;
        lat_size_nx    = lat_size;
        lat_signed_nx  = lat_signed;
        lat_lane_nx    = lat_lane;
        lat_addr_nx    = lat_addr;
        bus_req_nx     = bus_req;
        bus_we_nx      = bus_we;
        bus_addr_nx    = bus_addr;
        bus_be_nx      = bus_be;
        bus_wdata_nx   = bus_wdata;
        if_inst_nx     = '0;
        if_valid_nx    = 1'b0;
        d_rdata_nx     = '0;
        d_valid_nx     = 1'b0;
        d_err_nx       = 1'b0;
        raise_fault    = 1'b0;
        fault_src      = lat_addr;

        case (state)
            S_IDLE: begin
                if (d_req && (!if_req || prefer_data)) begin
                    prefer_data_nx = 1'b0;
                    lat_addr_nx    = d_addr;
                    lat_off_nx     = d_off;
                    lat_size_nx    = d_size;
                    lat_signed_nx  = d_signed;
                    if (d_bad) begin
                        state_nx    = S_RESP;
                        d_valid_nx  = 1'b1;
                        d_err_nx    = 1'b1;
                        raise_fault = 1'b1;
                        fault_src   = d_addr;
                    end else begin
                        state_nx     = S_DACC;
                        tmo_cnt_nx   = '0;
                        bus_req_nx   = 1'b1;
                        bus_we_nx    = d_write;
                        bus_addr_nx  = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus_be_nx    = be_base << d_off;
                        bus_wdata_nx = d_write ? (d_wdata << {d_off, 3'b000}) : '0;
                    end
                end else if (if_req) begin
                    prefer_data_nx = 1'b1;
                    lat_addr_nx    = if_addr;
                    lat_lane_nx    = (WORD > INST_SIZE) ? if_addr[2] : 1'b0;
                    if (f_bad) begin
                        state_nx    = S_RESP;
                        if_valid_nx = 1'b1;
                        raise_fault = 1'b1;
                        fault_src   = if_addr;
                    end else begin
                        state_nx     = S_FACC;
                        tmo_cnt_nx   = '0;
                        bus_req_nx   = 1'b1;
                        bus_we_nx    = 1'b0;
                        bus_addr_nx  = {if_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus_be_nx    = '1;
                        bus_wdata_nx = '0;
                    end
                end
            end
            S_DACC, S_FACC: begin
                // Ack wins over a timeout landing in the same cycle
                if (bus_ack || timed_out) begin
                    state_nx     = S_RESP;
                    bus_req_nx   = 1'b0;
                    bus_we_nx    = 1'b0;
                    bus_addr_nx  = '0;
                    bus_be_nx    = '0;
                    bus_wdata_nx = '0;
                    raise_fault  = bus_ack ? bus_err : 1'b1;
                    if (state == S_DACC) begin
                        d_valid_nx = 1'b1;
                        d_err_nx   = raise_fault;
                        d_rdata_nx = raise_fault ? '0 : ld_data;
                    end else begin
                        if_valid_nx = 1'b1;
                        if_inst_nx  = raise_fault ? '0 : INST_SIZE'(inst_shift);
                    end
                end else if (tmo_cnt != CNT_MAX) begin
                    tmo_cnt_nx = tmo_cnt + CNT_W'(1);
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        fault_nx      = fault | raise_fault;
        fault_addr_nx = (raise_fault && !fault) ? fault_src : fault_addr;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            prefer_data <= 1'b1;
            tmo_cnt     <= '0;
            lat_off     <= '0;
            lat_size    <= '0;
            lat_signed  <= 1'b0;
            lat_lane    <= 1'b0;
            lat_addr    <= '0;
            if_inst     <= '0;
            if_valid    <= 1'b0;
            d_rdata     <= '0;
            d_valid     <= 1'b0;
            d_err       <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            fault       <= 1'b0;
            fault_addr  <= '0;
        end else begin
            state       <= state_nx;
            prefer_data <= prefer_data_nx;
            tmo_cnt     <= tmo_cnt_nx;
            lat_off     <= lat_off_nx;
            lat_size    <= lat_size_nx;
            lat_signed  <= lat_signed_nx;
            lat_lane    <= lat_lane_nx;
            lat_addr    <= lat_addr_nx;
            if_inst     <= if_inst_nx;
            if_valid    <= if_valid_nx;
            d_rdata     <= d_rdata_nx;
            d_valid     <= d_valid_nx;
            d_err       <= d_err_nx;
            bus_req     <= bus_req_nx;
            bus_we      <= bus_we_nx;
            bus_addr    <= bus_addr_nx;
            bus_be      <= bus_be_nx;
            bus_wdata   <= bus_wdata_nx;
            fault       <= fault_nx;
            fault_addr  <= fault_addr_nx;
        end
    end
endmodule

// File: tb/tb_mem_bus_unit.sv
// tb_mem_bus_unit: directed plus randomized bench for mem_bus_unit (WORD=64, TIMEOUT=4).
// The bench plays both the core and the bus slave; expectations come from a
// small arithmetic model of lanes, extension, arbitration and fault tracking.
module tb_mem_bus_unit;
    localparam int unsigned WORD      = 64;
    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned INST_SIZE = 32;
    localparam int unsigned TIMEOUT   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 if_req;
    logic [ADDR_W-1:0]    if_addr;
    logic [INST_SIZE-1:0] if_inst;
    logic                 if_valid;
    logic                 d_read, d_write, d_signed;
    logic [1:0]           d_size;
    logic [ADDR_W-1:0]    d_addr;
    logic [WORD-1:0]      d_wdata, d_rdata;
    logic                 d_valid, d_err, stall;
    logic                 bus_req, bus_we;
    logic [ADDR_W-1:0]    bus_addr;
    logic [WORD/8-1:0]    bus_be;
    logic [WORD-1:0]      bus_wdata, bus_rdata;
    logic                 bus_ack, bus_err;
    logic                 fault;
    logic [ADDR_W-1:0]    fault_addr;

    mem_bus_unit #(
        .WORD(WORD), .ADDR_W(ADDR_W), .INST_SIZE(INST_SIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_valid(if_valid),
        .d_read(d_read), .d_write(d_write), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .d_err(d_err), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    bit          m_fault;
    logic [63:0] m_fault_addr;
    bit          m_data_next;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_data_bad(bit rd, bit wr, logic [1:0] sz, logic [63:0] a);
        int nb  = 1 << sz;
        int off = int'(a % 64'd8);
        return (rd && wr) || ((off % nb) != 0);
    endfunction

    function automatic logic [7:0] m_be(logic [1:0] sz, logic [63:0] a);
        int nb  = 1 << sz;
        int off = int'(a % 64'd8);
        return 8'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [63:0] m_load(logic [1:0] sz, bit sg, logic [63:0] a, logic [63:0] rdat);
        int          bits = 8 << sz;
        logic [63:0] v    = rdat >> (64'd8 * (a % 64'd8));
        if (bits < 64) begin
            logic [63:0] span = 64'd1 << bits;
            v = v % span;
            if (sg && v >= span / 64'd2) v = v - span;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_inst(logic [63:0] a, logic [63:0] rdat);
        return 32'(rdat >> (64'd32 * ((a / 64'd4) % 64'd2)));
    endfunction

    // One complete transaction: core request, slave response after 'waits'
    // wait cycles (negative: never acks), completion and pulse-width checks.
    task automatic run_txn(input bit fetch, input bit rd, input bit wr, input logic [1:0] sz,
                           input bit sg, input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] rdat, input int waits, input bit serr);
        bit bad, fail_exp, got;
        int cyc, rc, exp_cyc, exp_rc;
        bad = fetch ? ((a % 64'd4) != 0) : m_data_bad(rd, wr, sz, a);
        if (fetch) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            d_read = rd; d_write = wr; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
        end
        cyc = 0; rc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
            got = fetch ? if_valid : d_valid;
            if (!got) begin
                check("stall_busy", 64'(stall), 64'd1);
                if (bus_req) begin
                    if (rc == 0) begin
                        check("bus_addr", bus_addr, a - (a % 64'd8));
                        check("bus_be", 64'(bus_be), fetch ? 64'hFF : 64'(m_be(sz, a)));
                        check("bus_we", 64'(bus_we), fetch ? 64'd0 : 64'(wr));
                        if (!fetch && wr) check("bus_wdata", bus_wdata, wd << (64'd8 * (a % 64'd8)));
                    end
                    rc++;
                    if (waits >= 0 && rc == waits + 1) begin
                        bus_ack = 1'b1; bus_err = serr; bus_rdata = rdat;
                    end
                end
            end
        end
        exp_cyc  = bad ? 1 : ((waits < 0) ? int'(TIMEOUT) + 1 : waits + 2);
        exp_rc   = bad ? 0 : ((waits < 0) ? int'(TIMEOUT) : waits + 1);
        fail_exp = bad || (waits < 0) || serr;
        check("pulse_seen", 64'(got), 64'd1);
        check("latency", 64'(cyc), 64'(exp_cyc));
        check("bus_cycles", 64'(rc), 64'(exp_rc));
        check("bus_req_drop", 64'(bus_req), 64'd0);
        check("stall_done", 64'(stall), 64'd0);
        if (fetch) begin
            check("if_inst", 64'(if_inst), fail_exp ? 64'd0 : 64'(m_inst(a, rdat)));
            check("d_valid_quiet", 64'(d_valid), 64'd0);
        end else begin
            check("d_err", 64'(d_err), 64'(fail_exp));
            if (fail_exp || !wr) check("d_rdata", d_rdata, fail_exp ? 64'd0 : m_load(sz, sg, a, rdat));
            check("if_valid_quiet", 64'(if_valid), 64'd0);
        end
        if (fail_exp) begin
            if (!m_fault) m_fault_addr = a;
            m_fault = 1'b1;
        end
        check("fault", 64'(fault), 64'(m_fault));
        check("fault_addr", fault_addr, m_fault_addr);
        m_data_next = fetch;
        if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        check("pulse_width", fetch ? 64'(if_valid) : 64'(d_valid), 64'd0);
        check("idle_bus", 64'(bus_req), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, wd, rdat, last_rdat;
        logic [1:0]  sz;
        bit          fetch, rd, wr, sg, serr, expect_data;
        int          w, nd, nf, ng, r;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_size = '0; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
        bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
        m_fault = 1'b0; m_fault_addr = '0; m_data_next = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_bus_be", 64'(bus_be), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Both classes raised together from reset and held: D,F,D,F
        if_addr = 64'h300; d_addr = 64'h400; d_size = 2'b11; d_signed = 1'b0;
        d_write = 1'b0; d_read = 1'b1; if_req = 1'b1;
        nd = 0; nf = 0; ng = 0; expect_data = m_data_next; last_rdat = '0;
        for (int c = 0; c < 60 && (d_read || if_req); c++) begin
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = '0;
            if (d_valid) begin
                check("arb_d_rdata", d_rdata, last_rdat);
                nd++;
                if (nd == 2) d_read = 1'b0;
            end
            if (if_valid) begin
                nf++;
                if (nf == 2) if_req = 1'b0;
            end
            if (bus_req) begin
                check("arb_grant", bus_addr, expect_data ? 64'h400 : 64'h300);
                expect_data = !expect_data;
                ng++;
                last_rdat = {$urandom, $urandom};
                bus_ack = 1'b1; bus_rdata = last_rdat;
            end
        end
        check("arb_grants", 64'(ng), 64'd4);
        check("arb_data_done", 64'(nd), 64'd2);
        check("arb_fetch_done", 64'(nf), 64'd2);
        d_read = 1'b0; if_req = 1'b0;
        m_data_next = expect_data;
        @(negedge clk);

        // Directed lane / extension cases
        run_txn(1, 0, 0, 2'b10, 0, 64'h104, 64'h0, 64'hAAAA5555_12345678, 2, 0);
        run_txn(1, 0, 0, 2'b10, 0, 64'h108, 64'h0, 64'hAAAA5555_12345678, 0, 0);
        run_txn(0, 1, 0, 2'b00, 1, 64'h203, 64'h0, 64'h00000000_80000000, 1, 0);
        run_txn(0, 1, 0, 2'b00, 0, 64'h203, 64'h0, 64'h00000000_80000000, 0, 0);
        run_txn(0, 0, 1, 2'b01, 0, 64'h206, 64'hBEEF, 64'h0, 0, 0);
        run_txn(0, 1, 0, 2'b10, 1, 64'h20C, 64'h0, 64'h9234_5678_0000_0000, 3, 0);
        run_txn(0, 1, 0, 2'b11, 1, 64'h210, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 0);
        run_txn(0, 0, 1, 2'b10, 0, 64'h214, 64'h1122_3344_5566_7788, 64'h0, 1, 0);

        // Faults: misaligned (first), then slave error, timeout, both strobes, misaligned fetch
        run_txn(0, 1, 0, 2'b10, 0, 64'h101, 64'h0, 64'h0, 0, 0);
        run_txn(0, 1, 0, 2'b11, 0, 64'h208, 64'h0, 64'h1234, 1, 1);
        run_txn(0, 1, 0, 2'b01, 0, 64'h20A, 64'h0, 64'h0, -1, 0);
        run_txn(0, 1, 1, 2'b00, 0, 64'h220, 64'h55, 64'h0, 0, 0);
        run_txn(1, 0, 0, 2'b10, 0, 64'h102, 64'h0, 64'h0, 0, 0);

        // Reset in the middle of a bus cycle; a late ack must produce nothing
        d_read = 1'b1; d_write = 1'b0; d_size = 2'b11; d_addr = 64'h500;
        for (int c = 0; c < 10 && !bus_req; c++) @(negedge clk);
        check("rst_mid_req", 64'(bus_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_drop", 64'(bus_req), 64'd0);
        check("rst_mid_dvalid", 64'(d_valid), 64'd0);
        rst = 1'b0; d_read = 1'b0; bus_ack = 1'b1; bus_rdata = 64'hDEAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            check("late_ack_dvalid", 64'(d_valid), 64'd0);
            check("late_ack_ivalid", 64'(if_valid), 64'd0);
            check("late_ack_req", 64'(bus_req), 64'd0);
        end
        m_fault = 1'b0; m_fault_addr = '0; m_data_next = 1'b1;
        check("rst_fault_clr", 64'(fault), 64'd0);
        check("rst_fault_addr", fault_addr, 64'd0);

        // Randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            fetch = ($urandom_range(0, 2) == 0);
            a     = 64'h1000 + 64'($urandom_range(0, 255));
            rdat  = {$urandom, $urandom};
            wd    = {$urandom, $urandom};
            sz    = 2'($urandom_range(0, 3));
            sg    = 1'($urandom_range(0, 1));
            w     = $urandom_range(0, 3);
            serr  = 1'b0;
            rd    = 1'b0; wr = 1'b0;
            if (fetch) begin
                if ($urandom_range(0, 7) != 0) a = a - (a % 64'd4);
            end else begin
                r = $urandom_range(0, 15);
                if (r == 0) begin rd = 1'b1; wr = 1'b1; end
                else if (r < 8) rd = 1'b1;
                else wr = 1'b1;
                if ($urandom_range(0, 3) != 0) a = a - (a % (64'd1 << sz));
                if ($urandom_range(0, 7) == 0) serr = 1'b1;
                if ($urandom_range(0, 15) == 0) w = -1;
            end
            run_txn(fetch, rd, wr, sz, sg, a, wd, rdat, w, serr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
